// File: rtl/shift_add_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier_pkg
//   Shared definitions for the sequential shift-and-add multiplier.
//   Holds the controller state encodings used by the ALU sequencers and the
//   default operand width.
//
//   Contents:
//     DEFAULT_BUS_WIDTH  default operand width W
//     state_t            2-bit controller state type
//     ST_IDLE            waiting for operands (in_ready high)
//     ST_RUN             one shift-and-add step per clock
//     ST_DONE            product presented, waiting for out_ready
//     ST_UNUSED          unreachable encoding, recovers to ST_IDLE
// -----------------------------------------------------------------------------
package shift_add_multiplier_pkg;

    localparam int DEFAULT_BUS_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_UNUSED = 2'd3;

endpackage : shift_add_multiplier_pkg

// File: rtl/shift_add_multiplier_add.sv
// -----------------------------------------------------------------------------
// add
//   Unsigned BUS_WIDTH-bit adder with carry-out. This is the single adder the
//   multiplier time-shares across all of its shift-and-add steps.
//
//   Ports:
//     a      in   BUS_WIDTH  first addend
//     b      in   BUS_WIDTH  second addend
//     sum    out  BUS_WIDTH  low BUS_WIDTH bits of a+b
//     carry  out  1          carry-out of a+b
// -----------------------------------------------------------------------------
module add #(
    parameter int BUS_WIDTH = 16
) (
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    output logic [BUS_WIDTH-1:0] sum,
    output logic                 carry
);

    // Zero-extend both operands by one bit so the carry falls out of the
    // same addition without any width truncation.
    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule : add

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//   Unsigned sequential multiplier. Operands are accepted with a valid/ready
//   handshake, the product is built over BUS_WIDTH shift-and-add steps using a
//   single shared adder, and the 2*BUS_WIDTH-bit result is offered with a
//   valid/ready handshake. Only one operation is in flight at a time.
//
//   Ports:
//     clk        in   1            clock, all state updates on the rising edge
//     reset      in   1            synchronous, active-high reset
//     in_valid   in   1            operands a/b are valid
//     in_ready   out  1            block can accept operands (IDLE only)
//     a          in   BUS_WIDTH    multiplicand, unsigned
//     b          in   BUS_WIDTH    multiplier, unsigned
//     out_valid  out  1            product is valid (DONE only)
//     out_ready  in   1            consumer accepts the product
//     product    out  2*BUS_WIDTH  a*b, unsigned
//     busy       out  1            an operation is in progress or unread
// -----------------------------------------------------------------------------
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BUS_WIDTH-1:0]   a,
    input  logic [BUS_WIDTH-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*BUS_WIDTH-1:0] product,
    output logic                   busy
);

    // The step counter must be able to hold BUS_WIDTH-1; one spare bit keeps
    // the width the same as the rest of the ALU sequencers.
    localparam int               COUNT_W   = $clog2(BUS_WIDTH) + 1;
    localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(BUS_WIDTH - 1);

    state_t               state;
    state_t               state_next;

    logic [BUS_WIDTH-1:0] m;       // latched multiplicand
    logic [BUS_WIDTH-1:0] p_hi;    // upper half of the partial product
    logic [BUS_WIDTH-1:0] p_lo;    // lower half; starts as the multiplier
    logic [COUNT_W-1:0]   count;   // number of RUN steps already taken

    logic [BUS_WIDTH-1:0] add_sum;
    logic                 add_carry;

    logic accept;
    logic release_result;
    logic last_step;

    // -------------------------------------------------------------------------
    // Shared adder: always computes P_hi + M; the RUN step decides whether the
    // sum is used based on the current multiplier bit p_lo[0].
    // -------------------------------------------------------------------------
    add #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_add (
        .a     (p_hi),
        .b     (m),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    assign in_ready       = (state == ST_IDLE);
    assign out_valid      = (state == ST_DONE);
    assign busy           = (state != ST_IDLE);
    assign product        = {p_hi, p_lo};

    assign accept         = in_valid && in_ready;
    assign release_result = out_ready && out_valid;
    assign last_step      = (count == LAST_STEP);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and
        // no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (release_result) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                // ST_UNUSED is never entered; recover cleanly if it is.
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: operand capture, shift-and-add, step counter.
    // In DONE (and while waiting in IDLE) the registers hold, so the product
    // stays stable under backpressure.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            m     <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        m     <= a;
                        p_hi  <= '0;
                        p_lo  <= b;
                        count <= '0;
                    end
                end
                ST_RUN: begin
                    // Shift the whole partial product right by one; when the
                    // current multiplier bit is set, the adder result (with
                    // its carry as the new MSB) replaces the upper half.
                    if (p_lo[0]) begin
                        {p_hi, p_lo} <= {add_carry, add_sum, p_lo[BUS_WIDTH-1:1]};
                    end else begin
                        {p_hi, p_lo} <= {1'b0, p_hi, p_lo[BUS_WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                end
                default: begin
                    // DONE and unused encodings: hold the result.
                end
            endcase
        end
    end

endmodule : shift_add_multiplier
